two_power_mod: RTL and testbench

//  Computes R2 = 2^power mod N for the RSA datapath. Input is modulus N and exponent power.

---
 rtl/two_power_mod_pkg.sv | 27 ++
 rtl/two_power_mod_if.sv | 50 +++++
 rtl/two_power_mod_mod_double.sv | 18 +
 rtl/two_power_mod.sv | 108 ++++++++++
 tb/tb_two_power_mod.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/two_power_mod_pkg.sv
// Shared types for the R2 = 2^power mod N precompute stage.
// Default modulus width, power field width helper and FSM states.
package two_power_mod_pkg;

  localparam int MOD_WIDTH_DEFAULT = 256;

  function automatic int pow_w(input int w);
    return $clog2(2 * w + 1);
  endfunction

  localparam int POW_W_DEFAULT = pow_w(MOD_WIDTH_DEFAULT);

  typedef logic [MOD_WIDTH_DEFAULT-1:0] KeyType;
  typedef logic [POW_W_DEFAULT-1:0] PowerType;

  typedef struct packed {
    PowerType power;
    KeyType   modulus;
  } TwoPowerIn;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } TwoPowerState;

endpackage

// File: rtl/two_power_mod_if.sv
// Request/result handshake bundle for two_power_mod.
// o_bad exists only when RSA_TWO_POWER_CHECK_EN is defined.
interface two_power_mod_if
  import two_power_mod_pkg::*;
#(
  parameter int MOD_WIDTH = MOD_WIDTH_DEFAULT
);

  localparam int PW = pow_w(MOD_WIDTH);

  typedef struct packed {
    logic [PW-1:0]        power;
    logic [MOD_WIDTH-1:0] modulus;
  } in_t;

  logic                 i_valid;
  logic                 i_ready;
  in_t                  i_in;
  logic                 o_valid;
  logic                 o_ready;
  logic [MOD_WIDTH-1:0] o_out;
`ifdef RSA_TWO_POWER_CHECK_EN
  logic                 o_bad;
`endif

  modport master (
    output i_valid,
    output i_in,
    output o_ready,
    input  i_ready,
    input  o_valid,
`ifdef RSA_TWO_POWER_CHECK_EN
    input  o_bad,
`endif
    input  o_out
  );

  modport slave (
    input  i_valid,
    input  i_in,
    input  o_ready,
    output i_ready,
    output o_valid,
`ifdef RSA_TWO_POWER_CHECK_EN
    output o_bad,
`endif
    output o_out
  );

endinterface

// File: rtl/two_power_mod_mod_double.sv
// Combinational modular doubling: res = (2*acc) mod n, given acc < n.
// Reusable by later stages; one conditional subtraction suffices.
module mod_double #(
  parameter int W = 8
) (
  input  logic [W-1:0] acc,
  input  logic [W:0]   n,
  output logic [W-1:0] res
);

  logic [W:0] t;
  logic [W:0] d;

  assign t   = {acc, 1'b0};
  assign d   = t - n;
  assign res = (t >= n) ? d[W-1:0] : t[W-1:0];

endmodule

// File: rtl/two_power_mod.sv
// R2 = 2^power mod N, one modular doubling per cycle, valid/ready both sides.
// Define RSA_TWO_POWER_CHECK_EN to reject even or <2 moduli via o_bad.
module two_power_mod
  import two_power_mod_pkg::*;
#(
  parameter int MOD_WIDTH = MOD_WIDTH_DEFAULT
) (
  input logic            clk,
  input logic            rst,
  two_power_mod_if.slave bus
);

  localparam int PW = pow_w(MOD_WIDTH);

  TwoPowerState         state_q, state_d;
  logic [PW-1:0]        cnt_q, cnt_d;
  logic [MOD_WIDTH:0]   n_q, n_d;
  logic [MOD_WIDTH-1:0] acc_q, acc_d;
  logic [MOD_WIDTH-1:0] dbl;
  logic [MOD_WIDTH-1:0] in_mod;
  logic [PW-1:0]        in_pow;
  logic                 accept;

  assign in_mod = bus.i_in.modulus;
  assign in_pow = bus.i_in.power;
  assign accept = bus.i_valid && (state_q == IDLE);

  mod_double #(
    .W(MOD_WIDTH)
  ) u_dbl (
    .acc(acc_q),
    .n  (n_q),
    .res(dbl)
  );

`ifdef RSA_TWO_POWER_CHECK_EN
  logic bad_q, bad_d;
  logic in_bad;

  assign in_bad = !in_mod[0] || (in_mod == MOD_WIDTH'(1));
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    acc_d   = acc_q;
`ifdef RSA_TWO_POWER_CHECK_EN
    bad_d   = bad_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          n_d   = {1'b0, in_mod};
          cnt_d = in_pow;
          acc_d = (in_mod == MOD_WIDTH'(1)) ?
                  '0 : MOD_WIDTH'(1);
          state_d = (in_pow == '0) ? DONE : RUN;
`ifdef RSA_TWO_POWER_CHECK_EN
          bad_d = in_bad;
          if (in_bad) begin
            acc_d   = '0;
            state_d = DONE;
          end
`endif
        end
      end
      RUN: begin
        acc_d = dbl;
        cnt_d = cnt_q - PW'(1);
        if (cnt_d == '0) state_d = DONE;
      end
      DONE: begin
        if (bus.o_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      acc_q   <= acc_d;
    end
  end

  assign bus.i_ready = (state_q == IDLE);
  assign bus.o_valid = (state_q == DONE);
  assign bus.o_out   = (state_q == DONE) ? acc_q : '0;

`ifdef RSA_TWO_POWER_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bad_q <= 1'b0;
    else      bad_q <= bad_d;
  end

  assign bus.o_bad = (state_q == DONE) && bad_q;
`else
`endif

endmodule

// File: tb/tb_two_power_mod.sv
// Self-checking bench for two_power_mod at MOD_WIDTH=8.
// Reference: 2^power mod N via plain 64-bit arithmetic.
module tb_two_power_mod;

  import two_power_mod_pkg::*;

  localparam int W  = 8;
  localparam int PW = pow_w(W);

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  two_power_mod_if #(.MOD_WIDTH(W)) bus ();

  two_power_mod #(
    .MOD_WIDTH(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d",
               tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_r2(input int n,
                                         input int p);
    longint unsigned x;
    x = 64'd1 << p;
    return x % longint'(n);
  endfunction

  function automatic bit is_bad(input int n);
`ifdef RSA_TWO_POWER_CHECK_EN
    return (n % 2 == 0) || (n < 2);
`else
    return (n < 0);
`endif
  endfunction

  task automatic job(input int n, input int p,
                     input int stall, input bit hold_iv);
    int cyc;
    int exp_lat;
    bit bad;
    bit stable;
    bit busy_ok;
    logic [W-1:0] snap;
    logic [W-1:0] n8;
    logic [PW-1:0] p5;
    bad = is_bad(n);
    stable = 1'b1;
    busy_ok = 1'b1;
    n8 = n[W-1:0];
    p5 = p[PW-1:0];
    @(negedge clk);
    chk("i_ready_idle", 64'(bus.i_ready), 64'd1);
    bus.i_in.modulus = n8;
    bus.i_in.power   = p5;
    bus.i_valid      = 1'b1;
    bus.o_ready      = (stall == 0);
    @(posedge clk);
    #1;
    if (!hold_iv) bus.i_valid = 1'b0;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (bus.i_ready) busy_ok = 1'b0;
      if (bus.o_valid || cyc > 100) break;
    end
    exp_lat = bad ? 1 : p + 1;
    chk("latency", 64'(cyc), 64'(exp_lat));
    chk("o_out", 64'(bus.o_out),
        bad ? 64'd0 : ref_r2(n, p));
    chk("i_ready_busy", 64'(busy_ok), 64'd1);
`ifdef RSA_TWO_POWER_CHECK_EN
    chk("o_bad", 64'(bus.o_bad), 64'(bad));
`endif
    snap = bus.o_out;
    repeat (stall) begin
      @(negedge clk);
      if (!bus.o_valid || bus.o_out !== snap ||
          bus.i_ready)
        stable = 1'b0;
    end
    if (stall > 0) chk("hold_stable", 64'(stable), 64'd1);
    bus.o_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("pulse_end", 64'(bus.o_valid), 64'd0);
    chk("i_ready_back", 64'(bus.i_ready), 64'd1);
    bus.i_valid = 1'b0;
  endtask

  initial begin
    int n;
    int p;
    bus.i_valid = 1'b0;
    bus.o_ready = 1'b0;
    bus.i_in    = '0;
    rst = 1'b0;
    #12;
    chk("rst_i_ready", 64'(bus.i_ready), 64'd1);
    chk("rst_o_valid", 64'(bus.o_valid), 64'd0);
    chk("rst_o_out", 64'(bus.o_out), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    job(13, 4, 0, 1'b0);
    job(251, 16, 0, 1'b0);
    job(13, 0, 0, 1'b0);
    job(1, 5, 0, 1'b0);
    job(13, 4, 20, 1'b1);

    // Abort a running job with an async reset mid-RUN
    @(negedge clk);
    bus.i_in.modulus = 8'd251;
    bus.i_in.power   = 5'd16;
    bus.i_valid      = 1'b1;
    bus.o_ready      = 1'b1;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_o_valid", 64'(bus.o_valid), 64'd0);
    chk("abort_i_ready", 64'(bus.i_ready), 64'd1);
    chk("abort_o_out", 64'(bus.o_out), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    job(13, 4, 0, 1'b0);

`ifdef RSA_TWO_POWER_CHECK_EN
    job(12, 4, 0, 1'b0);
    job(13, 4, 0, 1'b0);
`endif

    repeat (40) begin
      n = int'($urandom_range(1, 255));
      p = int'($urandom_range(0, 31));
      job(n, p, int'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
